mem_seq_arbiter: RTL and testbench
==================================

Name: mem_seq_arbiter

Overview:
Sequential memory controller sharing the single byte-wide RAM bus between the instruction-fetch stage (32-bit reads) and the memory stage (1/2/4-byte reads and writes). It arbitrates requests, serialises each access into per-byte bus cycles, and assembles or disassembles little-endian words. It returns a one-cycle done pulse plus data to the winning requester. It drives per-requester stall requests into the stall controller and replaces the combinational memory mux between the pipeline and the top-level mem_a/mem_dout/mem_wr/mem_din pins.

Parameters:
ADDR_W, 32, width of address bus and request addresses
DATA_W, 32, width of requester data words (fixed 4 bytes)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
rdy  in  1  global ready; low pauses the block
if_req_i  in  1  fetch read request, level, held until if_done_o
if_addr_i  in  ADDR_W  fetch word address
if_done_o  out  1  one-cycle pulse, if_data_o valid
if_data_o  out  DATA_W  fetched word
if_stall_o  out  1  fetch stall request to the stall controller
mem_req_i  in  1  MEM-stage request, level, held until mem_done_o
mem_we_i  in  1  1=write, 0=read
mem_len_i  in  2  0:1 byte, 1:2 bytes, 2/3:4 bytes
mem_addr_i  in  ADDR_W  base byte address
mem_wdata_i  in  DATA_W  write data, byte i = bits 8i+7:8i
mem_done_o  out  1  one-cycle pulse, access complete
mem_rdata_o  out  DATA_W  read data, zero-extended
mem_stall_o  out  1  MEM stall request to the stall controller
ram_dout_i  in  8  RAM read byte; reflects the address of the previous rdy=1 cycle
ram_din_o  out  8  RAM write byte
ram_a_o  out  ADDR_W  RAM address
ram_wr_o  out  1  1=write

Behaviour:
- States: IDLE, IF_RD, MEM_RD, MEM_WR, DONE. Byte counter cnt (0..4). Latched base address, byte count N, write word, owner.
- Reset (rst=0, async): state IDLE, cnt 0; every output and all data/address registers 0. An in-flight access is aborted with no done pulse. ram_wr_o falls immediately.
- IDLE arbitration: mem_req_i wins over if_req_i (older instruction). Both active in the same cycle → MEM granted. IF waits.
- At grant, latch addr, len, we and wdata. Later changes to the inputs, including a dropped req, are ignored; an access always runs to completion.
- Read of N bytes, cycles C0..CN after grant:
  - In Cj with j<N: ram_a_o=base+j, ram_wr_o=0.
  - In Cj with j>=1: ram_dout_i is sampled into byte j-1.
  - In CN: ram_a_o=0.
  - End of CN: go to DONE.
  - IF accesses always use N=4.
- Write of N bytes, cycles C0..C(N-1): ram_a_o=base+j, ram_din_o=wdata byte j, ram_wr_o=1. End of C(N-1): go to DONE.
- DONE lasts one cycle:
  - The owner's done_o is high and its data output is valid; data is held until the next done for that owner.
  - No grant is taken in DONE, which gives requesters one cycle to drop or change req.
  - Next state is IDLE.
- Request-to-done latency: 4-byte read, done in the N+2 = 6th cycle after the request's IDLE cycle. 1-byte write, done 2 cycles after.
- Outside active bus cycles (IDLE, DONE): ram_a_o=0, ram_din_o=0, ram_wr_o=0.
- ram_* outputs are decoded only from registered state. There is no combinational path from req inputs to ram_*.
- Stall outputs (combinational):
  - if_stall_o = if_req_i & ~if_done_o
  - mem_stall_o = mem_req_i & ~mem_done_o
- rdy=0:
  - All registers hold, including state, cnt and captured bytes.
  - ram_wr_o is forced 0; ram_a_o holds.
  - Done pulses are extended: a done held across rdy=0 is delivered when rdy returns, and it lasts one rdy=1 cycle.
- Address wrap: base+j wraps modulo 2^ADDR_W.

Test Plan:
- IF req addr 0x100, RAM bytes 13,05,10,00 → ram_a_o 0x100..0x103 in C0..C3 with ram_wr_o=0; if_done_o=1 in C5 with if_data_o=0x00100513; if_stall_o high until then.
- Simultaneous IF req (0x104) and MEM write byte 0xAB to 0x30000 → C0: ram_wr_o=1, ram_a_o=0x30000, ram_din_o=0xAB; then mem_done_o pulse; IF granted the cycle after DONE.
- MEM write len=1, data 0x0000BEEF, addr 0x200 → two write cycles (0x200←EF, 0x201←BE); no write at 0x202.
- MEM read len=0 addr 0x8, RAM byte 0xF0 → mem_rdata_o=0x000000F0, done in C2.
- rdy=0 for 3 cycles during IF read at cnt=2 → ram_wr_o=0, no state change; data identical to the no-pause run; done exactly 3 cycles later.
- rst=0 mid-write at cnt=1 → ram_wr_o=0 immediately, state IDLE, no done pulse; a new MEM req after release completes normally.

Source files
------------

// File: rtl/mem_seq_arbiter.sv
// Byte-serial RAM bus arbiter shared by instruction fetch (32-bit reads) and the
// MEM stage (1/2/4-byte reads/writes); assembles little-endian words.
module mem_seq_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_done_o,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_stall_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_len_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic              mem_done_o,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_stall_o,
    input  logic [7:0]        ram_dout_i,
    output logic [7:0]        ram_din_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic              ram_wr_o
);

    typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

    state_t            state_q;
    logic [2:0]        cnt_q;
    logic [2:0]        n_q;
    logic [ADDR_W-1:0] base_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rbuf_q;
    logic [DATA_W-1:0] rbuf_d;
    logic              owner_q;
    logic [DATA_W-1:0] if_data_q;
    logic [DATA_W-1:0] mem_rdata_q;
    logic [2:0]        len_n;
    logic [1:0]        bidx;

    always_comb begin
        case (mem_len_i)
            2'd0:    len_n = 3'd1;
            2'd1:    len_n = 3'd2;
            default: len_n = 3'd4;
        endcase
    end

    // Byte arriving in cycle Cj belongs to the address issued in C(j-1).
    assign bidx = cnt_q[1:0] - 2'd1;

    always_comb begin
        rbuf_d = rbuf_q;
        if (cnt_q != 3'd0) begin
            rbuf_d[{bidx, 3'b000} +: 8] = ram_dout_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            base_q      <= '0;
            wdata_q     <= '0;
            rbuf_q      <= '0;
            owner_q     <= 1'b0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
        end else if (rdy) begin
            case (state_q)
                IDLE: begin
                    cnt_q  <= '0;
                    rbuf_q <= '0;
                    if (mem_req_i) begin
                        owner_q <= 1'b1;
                        base_q  <= mem_addr_i;
                        n_q     <= len_n;
                        wdata_q <= mem_wdata_i;
                        state_q <= mem_we_i ? MEM_WR : MEM_RD;
                    end else if (if_req_i) begin
                        owner_q <= 1'b0;
                        base_q  <= if_addr_i;
                        n_q     <= 3'd4;
                        wdata_q <= '0;
                        state_q <= IF_RD;
                    end
                end
                IF_RD, MEM_RD: begin
                    rbuf_q <= rbuf_d;
                    if (cnt_q == n_q) begin
                        state_q <= DONE;
                        if (owner_q) mem_rdata_q <= rbuf_d;
                        else         if_data_q   <= rbuf_d;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                MEM_WR: begin
                    if (cnt_q == n_q - 3'd1) state_q <= DONE;
                    else                     cnt_q   <= cnt_q + 3'd1;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Bus pins depend only on registered state (plus the rdy write gate).
    always_comb begin
        ram_a_o   = '0;
        ram_din_o = '0;
        ram_wr_o  = 1'b0;
        case (state_q)
            IF_RD, MEM_RD: begin
                if (cnt_q < n_q) ram_a_o = base_q + ADDR_W'(cnt_q);
            end
            MEM_WR: begin
                ram_a_o   = base_q + ADDR_W'(cnt_q);
                ram_din_o = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                ram_wr_o  = rdy;
            end
            default: ;
        endcase
    end

    assign if_done_o   = (state_q == DONE) && !owner_q;
    assign mem_done_o  = (state_q == DONE) && owner_q;
    assign if_data_o   = if_data_q;
    assign mem_rdata_o = mem_rdata_q;
    assign if_stall_o  = if_req_i & ~if_done_o;
    assign mem_stall_o = mem_req_i & ~mem_done_o;

endmodule

// File: tb/tb_mem_seq_arbiter.sv
// Bench for mem_seq_arbiter: byte-wide RAM model plus a word-level reference
// of each access (bytes, addresses, latency in ready cycles).
module tb_mem_seq_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done_o;
    logic [31:0] if_data_o;
    logic        if_stall_o;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [1:0]  mem_len = '0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_done_o;
    logic [31:0] mem_rdata_o;
    logic        mem_stall_o;
    logic [7:0]  ram_dout = 8'h00;
    logic [7:0]  ram_din_o;
    logic [31:0] ram_a_o;
    logic        ram_wr_o;

    int checks = 0;
    int failures = 0;

    typedef struct packed { logic [31:0] a; logic [7:0] d; } wr_t;
    wr_t wlog[$];
    logic [7:0] ram [logic [31:0]];

    always #5 clk = ~clk;

    mem_seq_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_done_o(if_done_o),
        .if_data_o(if_data_o), .if_stall_o(if_stall_o),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_len_i(mem_len),
        .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata), .mem_done_o(mem_done_o),
        .mem_rdata_o(mem_rdata_o), .mem_stall_o(mem_stall_o),
        .ram_dout_i(ram_dout), .ram_din_o(ram_din_o), .ram_a_o(ram_a_o),
        .ram_wr_o(ram_wr_o)
    );

    function automatic logic [7:0] rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    // RAM: every asserted write lands; read data follows the last ready-cycle address.
    always @(posedge clk) begin
        if (ram_wr_o) begin
            ram[ram_a_o] = ram_din_o;
            wlog.push_back('{a: ram_a_o, d: ram_din_o});
        end
        if (rdy) ram_dout <= rd(ram_a_o);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_access(input bit is_mem, input bit we, input logic [1:0] len,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input bit rnd_rdy);
        int n, exp_edges, edges;
        bit got, ok;
        logic [31:0] exp_data, got_data;
        n = !is_mem ? 4 : (len == 2'd0 ? 1 : (len == 2'd1 ? 2 : 4));
        exp_edges = (is_mem && we) ? n + 1 : n + 2;
        exp_data = '0;
        for (int j = 0; j < n; j++) exp_data[8*j +: 8] = rd(addr + 32'(j));
        wlog.delete();
        if (is_mem) begin
            mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        edges = 0;
        got = 1'b0;
        for (int t = 0; t < 200 && !got; t++) begin
            if (rnd_rdy) rdy = ($urandom_range(0, 3) != 0);
            if (rdy) edges++;
            tick();
            if ((is_mem ? mem_done_o : if_done_o) === 1'b1) got = 1'b1;
            else begin
                checks++;
                if ((is_mem ? mem_stall_o : if_stall_o) !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_wait: got 0 required 1 (addr %h)", addr);
                end
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL done_timeout: no done within 200 cycles (addr %h)", addr);
        end else begin
            checks++;
            if (edges != exp_edges) begin
                failures++;
                $display("FAIL latency: got %0d ready cycles required %0d (addr %h)", edges, exp_edges, addr);
            end
            checks++;
            if ((is_mem ? mem_stall_o : if_stall_o) !== 1'b0) begin
                failures++;
                $display("FAIL stall_at_done: got 1 required 0");
            end
            checks++;
            if (is_mem && we) begin
                ok = (wlog.size() == n);
                for (int j = 0; j < n && ok; j++)
                    if (wlog[j] !== {addr + 32'(j), wdata[8*j +: 8]}) ok = 1'b0;
                if (!ok) begin
                    failures++;
                    $display("FAIL write_bytes: got %0d writes required %0d at base %h data %h",
                             wlog.size(), n, addr, wdata);
                end
            end else begin
                got_data = is_mem ? mem_rdata_o : if_data_o;
                if (got_data !== exp_data) begin
                    failures++;
                    $display("FAIL read_data: got %h required %h (addr %h)", got_data, exp_data, addr);
                end
            end
        end
        mem_req = 1'b0;
        if_req = 1'b0;
        rdy = 1'b1;
        tick();
        checks++;
        if ({if_done_o, mem_done_o} !== 2'b00) begin
            failures++;
            $display("FAIL done_pulse_width: got %b required 00", {if_done_o, mem_done_o});
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        repeat (3) tick();
        checks++;
        if ({if_done_o, if_data_o, if_stall_o, mem_done_o, mem_rdata_o, mem_stall_o,
             ram_din_o, ram_a_o, ram_wr_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: ram_a %h wr %b din %h if_data %h mem_rdata %h",
                     ram_a_o, ram_wr_o, ram_din_o, if_data_o, mem_rdata_o);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({ram_a_o, ram_wr_o, if_done_o, mem_done_o} !== '0) begin
            failures++;
            $display("FAIL idle_after_reset: ram_a %h wr %b", ram_a_o, ram_wr_o);
        end
    endtask

    task automatic test_if_fetch();
        ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h10; ram[32'h103] = 8'h00;
        if_req = 1'b1; if_addr = 32'h100;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (k <= 4) begin
                if ({ram_a_o, ram_wr_o, if_done_o, if_stall_o} !== {32'h100 + 32'(k - 1), 3'b001}) begin
                    failures++;
                    $display("FAIL fetch_bus_c%0d: got a=%h wr=%b done=%b stall=%b required a=%h wr=0 done=0 stall=1",
                             k - 1, ram_a_o, ram_wr_o, if_done_o, if_stall_o, 32'h100 + 32'(k - 1));
                end
            end else if (k == 5) begin
                if ({ram_a_o, ram_wr_o, if_done_o} !== 34'b0) begin
                    failures++;
                    $display("FAIL fetch_c4: got a=%h done=%b required a=0 done=0", ram_a_o, if_done_o);
                end
            end else begin
                if ({if_done_o, if_stall_o, if_data_o} !== {2'b10, 32'h00100513}) begin
                    failures++;
                    $display("FAIL fetch_done: got done=%b stall=%b data=%h required 1 0 00100513",
                             if_done_o, if_stall_o, if_data_o);
                end
            end
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_priority();
        logic [31:0] w;
        int k;
        w = $urandom;
        for (int j = 0; j < 4; j++) ram[32'h104 + 32'(j)] = w[8*j +: 8];
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd0; mem_addr = 32'h30000; mem_wdata = 32'h000000AB;
        if_req = 1'b1; if_addr = 32'h104;
        tick();
        checks++;
        if ({ram_wr_o, ram_a_o, ram_din_o, if_stall_o, mem_stall_o} !== {1'b1, 32'h30000, 8'hAB, 2'b11}) begin
            failures++;
            $display("FAIL priority_c0: got wr=%b a=%h din=%h required wr=1 a=00030000 din=ab",
                     ram_wr_o, ram_a_o, ram_din_o);
        end
        tick();
        checks++;
        if ({mem_done_o, if_done_o, mem_stall_o, if_stall_o} !== 4'b1001) begin
            failures++;
            $display("FAIL priority_done: got mem_done=%b if_done=%b mem_stall=%b if_stall=%b required 1 0 0 1",
                     mem_done_o, if_done_o, mem_stall_o, if_stall_o);
        end
        mem_req = 1'b0;
        tick();
        checks++;
        if ({ram_a_o, ram_wr_o, mem_done_o, if_done_o} !== '0) begin
            failures++;
            $display("FAIL priority_gap: got a=%h wr=%b required idle bus", ram_a_o, ram_wr_o);
        end
        tick();
        checks++;
        if ({ram_a_o, ram_wr_o} !== {32'h104, 1'b0}) begin
            failures++;
            $display("FAIL priority_if_grant: got a=%h wr=%b required a=00000104 wr=0", ram_a_o, ram_wr_o);
        end
        k = 0;
        while (k < 20 && if_done_o !== 1'b1) begin
            tick();
            k++;
        end
        checks++;
        if (k != 5 || if_data_o !== w) begin
            failures++;
            $display("FAIL priority_if_data: got %h after %0d cycles required %h after 5", if_data_o, k, w);
        end
        checks++;
        if (rd(32'h30000) !== 8'hAB) begin
            failures++;
            $display("FAIL priority_ram_byte: got %h required ab", rd(32'h30000));
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_write_len1();
        ram[32'h202] = 8'h5A;
        run_access(1'b1, 1'b1, 2'd1, 32'h200, 32'h0000BEEF, 1'b0);
        checks++;
        if (wlog.size() != 2 || rd(32'h200) !== 8'hEF || rd(32'h201) !== 8'hBE || rd(32'h202) !== 8'h5A) begin
            failures++;
            $display("FAIL half_write: got %0d writes bytes %h %h %h required 2 writes ef be 5a",
                     wlog.size(), rd(32'h200), rd(32'h201), rd(32'h202));
        end
    endtask

    task automatic test_read_byte();
        ram[32'h8] = 8'hF0; ram[32'h9] = 8'h77;
        run_access(1'b1, 1'b0, 2'd0, 32'h8, 32'h0, 1'b0);
        checks++;
        if (mem_rdata_o !== 32'h000000F0) begin
            failures++;
            $display("FAIL byte_read_zext: got %h required 000000f0", mem_rdata_o);
        end
    endtask

    task automatic test_rdy_pause();
        int k;
        if_req = 1'b1; if_addr = 32'h100;
        repeat (3) tick();
        rdy = 1'b0;
        for (int p = 0; p < 3; p++) begin
            tick();
            checks++;
            if ({ram_wr_o, ram_a_o, if_done_o} !== {1'b0, 32'h102, 1'b0}) begin
                failures++;
                $display("FAIL pause_hold: got wr=%b a=%h done=%b required 0 00000102 0",
                         ram_wr_o, ram_a_o, if_done_o);
            end
        end
        rdy = 1'b1;
        k = 0;
        while (k < 20 && if_done_o !== 1'b1) begin
            tick();
            k++;
        end
        checks++;
        if (k != 3 || if_data_o !== 32'h00100513) begin
            failures++;
            $display("FAIL pause_done: got %h after %0d cycles required 00100513 after 3", if_data_o, k);
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_midwrite();
        logic [31:0] w;
        bit seen;
        w = $urandom;
        for (int j = 0; j < 4; j++) ram[32'h400 + 32'(j)] = 8'h00;
        wlog.delete();
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd2; mem_addr = 32'h400; mem_wdata = w;
        tick();
        tick();
        checks++;
        if ({ram_wr_o, ram_a_o} !== {1'b1, 32'h401}) begin
            failures++;
            $display("FAIL midwrite_c1: got wr=%b a=%h required 1 00000401", ram_wr_o, ram_a_o);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({ram_wr_o, ram_a_o, ram_din_o, mem_done_o, mem_rdata_o, if_data_o} !== '0) begin
            failures++;
            $display("FAIL async_reset: got wr=%b a=%h din=%h done=%b", ram_wr_o, ram_a_o, ram_din_o, mem_done_o);
        end
        mem_req = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            tick();
            if (mem_done_o !== 1'b0 || ram_wr_o !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL aborted_done: got done or write after reset required none");
        end
        checks++;
        if (wlog.size() != 1 || wlog[0] !== {32'h400, w[7:0]}) begin
            failures++;
            $display("FAIL aborted_writes: got %0d writes required 1 (400<-%h)", wlog.size(), w[7:0]);
        end
        run_access(1'b1, 1'b0, 2'd2, 32'h400, 32'h0, 1'b0);
    endtask

    task automatic test_random();
        bit is_mem, we;
        logic [1:0] len;
        logic [31:0] addr;
        for (int i = 0; i < 40; i++) begin
            is_mem = ($urandom_range(0, 2) != 0);
            we = is_mem && $urandom_range(0, 1);
            len = 2'($urandom_range(0, 3));
            addr = 32'h1000 + 32'($urandom_range(0, 63));
            if (i == 0) begin is_mem = 1'b1; we = 1'b1; len = 2'd3; addr = 32'hFFFF_FFFE; end
            if (i == 1) begin is_mem = 1'b0; we = 1'b0; addr = 32'hFFFF_FFFE; end
            run_access(is_mem, we, len, addr, $urandom, 1'b1);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_if_fetch();
        test_priority();
        test_write_len1();
        test_read_byte();
        test_rdy_pause();
        test_reset_midwrite();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
